mips_mem_responder: RTL and testbench
=====================================

MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data and address width in bits; the storage depth SHALL be 2^WIDTH bytes.
REQ-002 The block SHALL have parameter IO_ADR, default 8'hFF, giving the address of the memory-mapped output register.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port memread, input, 1 bit: processor read request.
REQ-006 Port memwrite, input, 1 bit: processor write request.
REQ-007 Port adr, input, WIDTH bits: processor byte address.
REQ-008 Port writedata, input, WIDTH bits: processor store data.
REQ-009 Port memdata, output, WIDTH bits: read data returned to the processor.
REQ-010 Port ld_valid, input, 1 bit: a boot-load byte is offered.
REQ-011 Port ld_data, input, 8 bits: the boot-load byte.
REQ-012 Port ld_last, input, 1 bit: the offered byte is the final image byte.
REQ-013 Port ld_ready, output, 1 bit: the block accepts a boot-load byte.
REQ-014 Port cpu_reset, output, 1 bit: reset to the processor.
REQ-015 Port io_out, output, WIDTH bits: memory-mapped output register.
REQ-016 Port io_strobe, output, 1 bit: one-cycle pulse after each io_out update.

Function
REQ-017 The block SHALL implement a two-state FSM with states LOAD and RUN; reset SHALL force LOAD.
REQ-018 In LOAD, ld_ready SHALL be 1 and cpu_reset SHALL be 1; in RUN, both SHALL be 0; both SHALL be driven from registered state.
REQ-019 A load transfer SHALL occur on a rising edge where ld_valid and ld_ready are both 1; it SHALL write ld_data to mem[ptr] and increment the WIDTH-bit load pointer ptr.
REQ-020 ptr SHALL wrap from 2^WIDTH-1 to 0 and loading SHALL continue, overwriting earlier bytes.
REQ-021 A transfer with ld_last=1 SHALL move the FSM to RUN on that same edge; ld_last without ld_valid SHALL be ignored.
REQ-022 In RUN, ld_valid, ld_data and ld_last SHALL be ignored; the FSM SHALL leave RUN only on reset.
REQ-023 In RUN with memread=1, memdata SHALL combinationally equal mem[adr], or io_out when adr==IO_ADR, within the same cycle (zero-latency read, as required by the processor's IR/MDR capture).
REQ-024 memdata SHALL be 0 when memread=0 or the FSM is in LOAD.
REQ-025 In RUN with memwrite=1 and adr!=IO_ADR, mem[adr] SHALL be written with writedata on the rising edge.
REQ-026 In RUN with memwrite=1 and adr==IO_ADR, io_out SHALL load writedata, mem SHALL NOT be written, and io_strobe SHALL be 1 for exactly the following cycle.
REQ-027 When memread and memwrite are both 1 to the same address, memdata SHALL show the pre-write value (read-before-write); the new value SHALL be visible from the next cycle.
REQ-028 memwrite SHALL be ignored in LOAD.
REQ-029 Back-to-back writes to IO_ADR SHALL produce io_strobe high on each following cycle, one strobe per write.

Reset
REQ-030 On reset: state=LOAD, ptr=0, io_out=0, io_strobe=0, cpu_reset=1, ld_ready=1.
REQ-031 Reset SHALL NOT clear the memory array; reset mid-load SHALL restart loading at address 0 and retain bytes already written.
REQ-032 A load transfer coincident with reset SHALL be discarded.

Verification
REQ-033 Load bytes 8'h80,8'h01,8'h02,8'h03 with ld_last on the 4th -> ld_ready drops and cpu_reset=0 from the next cycle; memread at adr 0..3 returns 80,01,02,03.
REQ-034 Stall ld_valid for 5 cycles mid-image -> ptr holds and no write occurs; the resumed byte lands at the next address.
REQ-035 Load 257 bytes (byte n = n[7:0]^8'h5A), last on the 257th -> mem[0] holds the 257th byte and mem[1..255] hold the first-pass values.
REQ-036 In RUN: memwrite adr=8'h10 data=8'hC3 with memread=1 -> memdata reads the old value that cycle and 8'hC3 the next.
REQ-037 In RUN: memwrite adr=8'hFF data=8'h2A -> io_out=8'h2A, io_strobe high for exactly one cycle, mem[255] unchanged; memread at 8'hFF returns 8'h2A.
REQ-038 Assert reset after 3 of 6 load bytes, then reload 2 bytes with ld_last -> mem[0..1] hold the new bytes, mem[2] keeps the old byte, and io_out=0.

Source files
------------

// File: rtl/mips_mem_responder_if.sv
// Bus between the MIPS core / boot loader and the memory responder.
// The responder sits on the slave modport; the core and the loader drive the master side.
interface mips_mem_responder_if #(
    parameter int WIDTH = 8
);
    // Processor side
    logic             memread;
    logic             memwrite;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] memdata;

    // Boot-load stream. A byte moves on a rising edge where ld_valid and
    // ld_ready are both 1. ld_ready never depends on ld_valid.
    // ld_data and ld_last are only looked at in a cycle where ld_valid is 1.
    logic             ld_valid;
    logic [7:0]       ld_data;
    logic             ld_last;
    logic             ld_ready;

    // Control, memory-mapped output and debug
    logic             cpu_reset;
    logic [WIDTH-1:0] io_out;
    logic             io_strobe;
    logic             fsm_state;   // 0 = LOAD, 1 = RUN

    modport master (
        output memread, memwrite, adr, writedata, ld_valid, ld_data, ld_last,
        input  memdata, ld_ready, cpu_reset, io_out, io_strobe, fsm_state
    );

    modport slave (
        input  memread, memwrite, adr, writedata, ld_valid, ld_data, ld_last,
        output memdata, ld_ready, cpu_reset, io_out, io_strobe, fsm_state
    );
endinterface

// File: rtl/mips_mem_responder.sv
// Byte memory for a small MIPS core. The memory is loaded from a byte stream while the core
// is held in reset, then serves zero-latency reads plus one memory-mapped output register.
module mips_mem_responder #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] IO_ADR = 8'hFF
) (
    input logic                  clk,
    input logic                  reset,
    mips_mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << WIDTH;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] io_out_q, io_out_d;
    logic             io_strobe_q, io_strobe_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             io_hit;
    logic             mem_we;
    logic [WIDTH-1:0] mem_wadr;
    logic [WIDTH-1:0] mem_wdata;

    assign io_hit = (bus.adr == IO_ADR);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        io_out_d    = io_out_q;
        io_strobe_d = 1'b0;
        mem_we      = 1'b0;
        mem_wadr    = ptr_q;
        mem_wdata   = WIDTH'(bus.ld_data);
        case (state_q)
            LOAD: begin
                if (bus.ld_valid) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + WIDTH'(1);
                    if (bus.ld_last) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.memwrite) begin
                    if (io_hit) begin
                        io_out_d    = bus.writedata;
                        io_strobe_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_wadr  = bus.adr;
                        mem_wdata = bus.writedata;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            ptr_q       <= '0;
            io_out_q    <= '0;
            io_strobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            io_out_q    <= io_out_d;
            io_strobe_q <= io_strobe_d;
        end
    end

    // The array keeps its contents through reset; only the write is gated so a
    // transfer coincident with reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[mem_wadr] <= mem_wdata;
        end
    end

    always_comb begin
        bus.memdata = '0;
        if (state_q == RUN && bus.memread) begin
            bus.memdata = io_hit ? io_out_q : mem_q[bus.adr];
        end
    end

    assign bus.ld_ready  = (state_q == LOAD);
    assign bus.cpu_reset = (state_q == LOAD);
    assign bus.io_out    = io_out_q;
    assign bus.io_strobe = io_strobe_q;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: boot load, stall, wrap, RUN reads/writes,
// the output register and reset in the middle of a load.
module tb_mips_mem_responder;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    mips_mem_responder_if #(.WIDTH(8)) bus ();

    mips_mem_responder #(.WIDTH(8), .IO_ADR(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus.memread = 1'b1;
        bus.adr     = a;
        #1;
        check(tag, bus.memdata, exp);
        bus.memread = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.adr       = '0;
        bus.writedata = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = '0;
        bus.ld_last   = 1'b0;
        tick();
        tick();
        check("rst_ld_ready", 8'(bus.ld_ready), 8'h01);
        check("rst_cpu_reset", 8'(bus.cpu_reset), 8'h01);
        check("rst_io_out", bus.io_out, 8'h00);
        check("rst_io_strobe", 8'(bus.io_strobe), 8'h00);
        check("rst_state", 8'(bus.fsm_state), 8'h00);
        reset = 1'b0;
        read_check("load_memdata_zero", 8'h00, 8'h00);

        // Basic four-byte image
        load_byte(8'h80, 1'b0);
        load_byte(8'h01, 1'b0);
        load_byte(8'h02, 1'b0);
        check("pre_last_ready", 8'(bus.ld_ready), 8'h01);
        load_byte(8'h03, 1'b1);
        check("run_ld_ready", 8'(bus.ld_ready), 8'h00);
        check("run_cpu_reset", 8'(bus.cpu_reset), 8'h00);
        check("run_state", 8'(bus.fsm_state), 8'h01);
        read_check("img_a0", 8'h00, 8'h80);
        read_check("img_a1", 8'h01, 8'h01);
        read_check("img_a2", 8'h02, 8'h02);
        read_check("img_a3", 8'h03, 8'h03);
        bus.adr = 8'h00;
        #1;
        check("noread_zero", bus.memdata, 8'h00);

        // Stall mid-image; ld_last without ld_valid must be ignored
        do_reset();
        load_byte(8'h11, 1'b0);
        load_byte(8'h22, 1'b0);
        bus.ld_data = 8'hEE;
        bus.ld_last = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.ld_last = 1'b0;
        check("stall_still_load", 8'(bus.ld_ready), 8'h01);
        load_byte(8'h33, 1'b1);
        read_check("stall_a0", 8'h00, 8'h11);
        read_check("stall_a1", 8'h01, 8'h22);
        read_check("stall_a2", 8'h02, 8'h33);
        read_check("stall_a3_old", 8'h03, 8'h03);

        // 257-byte image wraps the pointer
        do_reset();
        for (int n = 0; n < 256; n++) begin
            load_byte(8'(n) ^ 8'h5A, 1'b0);
        end
        check("wrap_still_load", 8'(bus.ld_ready), 8'h01);
        load_byte(8'h01, 1'b1);
        read_check("wrap_a0", 8'h00, 8'h01);
        read_check("wrap_a1", 8'h01, 8'h5B);
        read_check("wrap_a7f", 8'h7F, 8'h25);
        read_check("wrap_afe", 8'hFE, 8'hA4);
        check("wrap_mem255", dut.mem_q[255], 8'hA5);

        // Load stream is ignored in RUN
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'h77;
        bus.ld_last  = 1'b1;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        check("run_ignores_ld", 8'(bus.fsm_state), 8'h01);
        read_check("run_ld_nowrite", 8'h00, 8'h01);

        // Read-before-write at 0x10 (old value 0x10^0x5A)
        bus.memread   = 1'b1;
        bus.memwrite  = 1'b1;
        bus.adr       = 8'h10;
        bus.writedata = 8'hC3;
        #1;
        check("rbw_old", bus.memdata, 8'h4A);
        tick();
        bus.memwrite = 1'b0;
        #1;
        check("rbw_new", bus.memdata, 8'hC3);
        bus.memread = 1'b0;

        // Output register write
        bus.memwrite  = 1'b1;
        bus.adr       = 8'hFF;
        bus.writedata = 8'h2A;
        #1;
        check("io_strobe_before", 8'(bus.io_strobe), 8'h00);
        tick();
        bus.memwrite = 1'b0;
        check("io_out_2a", bus.io_out, 8'h2A);
        check("io_strobe_on", 8'(bus.io_strobe), 8'h01);
        tick();
        check("io_strobe_off", 8'(bus.io_strobe), 8'h00);
        check("io_mem255_kept", dut.mem_q[255], 8'hA5);
        read_check("io_readback", 8'hFF, 8'h2A);

        // Back-to-back output writes
        bus.memwrite  = 1'b1;
        bus.adr       = 8'hFF;
        bus.writedata = 8'h01;
        tick();
        check("b2b_out1", bus.io_out, 8'h01);
        check("b2b_strobe1", 8'(bus.io_strobe), 8'h01);
        bus.writedata = 8'h02;
        tick();
        bus.memwrite = 1'b0;
        check("b2b_out2", bus.io_out, 8'h02);
        check("b2b_strobe2", 8'(bus.io_strobe), 8'h01);
        tick();
        check("b2b_strobe_off", 8'(bus.io_strobe), 8'h00);

        // Reset after 3 of 6 bytes; the 4th is offered on the reset edge
        do_reset();
        load_byte(8'hA1, 1'b0);
        load_byte(8'hA2, 1'b0);
        load_byte(8'hA3, 1'b0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'hA4;
        reset        = 1'b1;
        tick();
        bus.ld_valid = 1'b0;
        reset        = 1'b0;
        check("midrst_io_out", bus.io_out, 8'h00);
        check("midrst_cpu_reset", 8'(bus.cpu_reset), 8'h01);
        bus.memwrite  = 1'b1;
        bus.adr       = 8'h02;
        bus.writedata = 8'hEE;
        tick();
        bus.memwrite = 1'b0;
        load_byte(8'hB1, 1'b0);
        load_byte(8'hB2, 1'b1);
        read_check("reload_a0", 8'h00, 8'hB1);
        read_check("reload_a1", 8'h01, 8'hB2);
        read_check("reload_a2", 8'h02, 8'hA3);
        read_check("reload_a3", 8'h03, 8'h59);
        check("reload_io_out", bus.io_out, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
